// File: rtl/id_stage_pipe.sv
// RV32I ALU decode (OP-IMM/OP/LUI/AUIPC) with EX/MEM forwarding, registered into an ID/EX stage.
// One cycle from accept to out_valid; holds while out_ready=0; flush drops held and incoming.
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit FWD_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           inst_i,
  output logic                  reg1_read_o,
  output logic                  reg2_read_o,
  output logic [REG_ADDR_W-1:0] reg1_addr_o,
  output logic [REG_ADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]       reg1_data_i,
  input  logic [XLEN-1:0]       reg2_data_i,
  input  logic                  ex_wd_i,
  input  logic [REG_ADDR_W-1:0] ex_wreg_i,
  input  logic [XLEN-1:0]       ex_wdata_i,
  input  logic                  mem_wd_i,
  input  logic [REG_ADDR_W-1:0] mem_wreg_i,
  input  logic [XLEN-1:0]       mem_wdata_i,
  input  logic                  flush_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            aluop_o,
  output logic [2:0]            alufunct3_o,
  output logic                  alufunct7b5_o,
  output logic [XLEN-1:0]       reg1_o,
  output logic [XLEN-1:0]       reg2_o,
  output logic [REG_ADDR_W-1:0] wreg_o,
  output logic                  wd_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  illegal_o
);
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [XLEN-1:0]       reg1;
    logic [XLEN-1:0]       reg2;
    logic [REG_ADDR_W-1:0] wreg;
    logic                  wd;
    logic [XLEN-1:0]       pc;
    logic                  illegal;
  } idex_t;

  idex_t                 idex_d, idex_q;
  logic                  valid_d, valid_q;
  logic                  load;
  logic [6:0]            opcode, funct7;
  logic [2:0]            funct3;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]       imm_i, imm_u, shamt;
  logic                  legal, rd1, rd2;
  logic [XLEN-1:0]       alt1, alt2, op1, op2;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign rs1    = REG_ADDR_W'(inst_i[19:15]);
  assign rs2    = REG_ADDR_W'(inst_i[24:20]);
  assign rd     = REG_ADDR_W'(inst_i[11:7]);
  assign imm_i  = XLEN'($signed(inst_i[31:20]));
  assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign shamt  = XLEN'(inst_i[24:20]);

  always_comb begin
    legal = 1'b0;
    rd1   = 1'b0;
    rd2   = 1'b0;
    alt1  = '0;
    alt2  = '0;
    case (opcode)
      OPC_OP_IMM: begin
        rd1   = 1'b1;
        legal = 1'b1;
        alt2  = imm_i;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          alt2  = shamt;
          legal = (funct7 == 7'b0000000) || (funct3 == 3'b101 && funct7 == 7'b0100000);
        end
      end
      OPC_OP: begin
        rd1   = 1'b1;
        rd2   = 1'b1;
        legal = (funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_LUI: begin
        legal = 1'b1;
        alt2  = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        alt1  = pc_i;
        alt2  = imm_u;
      end
      default: ;
    endcase
  end

  // x0 reads as zero ahead of any forward; EX is younger than MEM so it wins.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic rd_en, input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0] rf_data, input logic [XLEN-1:0] alt,
    input logic ex_wd, input logic [REG_ADDR_W-1:0] ex_wreg, input logic [XLEN-1:0] ex_wdata,
    input logic mem_wd, input logic [REG_ADDR_W-1:0] mem_wreg, input logic [XLEN-1:0] mem_wdata);
    if (!rd_en) return alt;
    if (addr == '0) return '0;
    if (FWD_EN && ex_wd && ex_wreg == addr) return ex_wdata;
    if (FWD_EN && mem_wd && mem_wreg == addr) return mem_wdata;
    return rf_data;
  endfunction

  assign op1 = pick_operand(rd1, rs1, reg1_data_i, alt1, ex_wd_i, ex_wreg_i, ex_wdata_i,
                            mem_wd_i, mem_wreg_i, mem_wdata_i);
  assign op2 = pick_operand(rd2, rs2, reg2_data_i, alt2, ex_wd_i, ex_wreg_i, ex_wdata_i,
                            mem_wd_i, mem_wreg_i, mem_wdata_i);

  always_comb begin
    idex_d          = '0;
    idex_d.op       = opcode;
    idex_d.funct3   = funct3;
    idex_d.funct7b5 = inst_i[30];
    idex_d.reg1     = legal ? op1 : '0;
    idex_d.reg2     = legal ? op2 : '0;
    idex_d.wreg     = rd;
    idex_d.wd       = legal && (rd != '0);
    idex_d.pc       = pc_i;
    idex_d.illegal  = !legal;
  end

  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready && !flush_i;

  always_comb begin
    valid_d = valid_q;
    if (flush_i)        valid_d = 1'b0;
    else if (load)      valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      idex_q    <= '0;
      idex_q.op <= OPC_OP_IMM;
    end else begin
      valid_q <= valid_d;
      if (load) idex_q <= idex_d;
    end
  end

  assign reg1_read_o   = !rst && rd1;
  assign reg2_read_o   = !rst && rd2;
  assign reg1_addr_o   = rst ? '0 : rs1;
  assign reg2_addr_o   = rst ? '0 : rs2;
  assign out_valid     = valid_q;
  assign aluop_o       = idex_q.op;
  assign alufunct3_o   = idex_q.funct3;
  assign alufunct7b5_o = idex_q.funct7b5;
  assign reg1_o        = idex_q.reg1;
  assign reg2_o        = idex_q.reg2;
  assign wreg_o        = idex_q.wreg;
  assign wd_o          = idex_q.wd;
  assign pc_o          = idex_q.pc;
  assign illegal_o     = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: vector table driven through the handshake, scoreboard checks ID/EX outputs.
module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wd_i, mem_wd_i;
  logic [4:0]  ex_wreg_i, mem_wreg_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        flush_i, out_valid, out_ready;
  logic [6:0]  aluop_o;
  logic [2:0]  alufunct3_o;
  logic        alufunct7b5_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [4:0]  wreg_o;
  logic        wd_o, illegal_o;

  id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
    .aluop_o(aluop_o), .alufunct3_o(alufunct3_o), .alufunct7b5_o(alufunct7b5_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .wreg_o(wreg_o), .wd_o(wd_o), .pc_o(pc_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc, r1, r2;
    logic        exwd;  logic [4:0] exwreg; logic [31:0] exwdata;
    logic        mwd;   logic [4:0] mwreg;  logic [31:0] mwdata;
    logic        re1, re2;
    logic [31:0] e1, e2; logic [4:0] ewreg; logic ewd, eill;
  } vec_t;

  typedef struct {
    logic [31:0] e1, e2, pc; logic [4:0] ewreg; logic ewd, eill;
    logic [6:0] op; logic [2:0] f3; logic f7b5;
  } exp_t;

  vec_t tbl[13];
  exp_t sb[$];
  exp_t got;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
    input logic exwd, input logic [4:0] exwreg, input logic [31:0] exwdata,
    input logic mwd, input logic [4:0] mwreg, input logic [31:0] mwdata,
    input logic re1, input logic re2, input logic [31:0] e1, input logic [31:0] e2,
    input logic [4:0] ewreg, input logic ewd, input logic eill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.r1 = r1; v.r2 = r2;
    v.exwd = exwd; v.exwreg = exwreg; v.exwdata = exwdata;
    v.mwd = mwd; v.mwreg = mwreg; v.mwdata = mwdata;
    v.re1 = re1; v.re2 = re2; v.e1 = e1; v.e2 = e2;
    v.ewreg = ewreg; v.ewd = ewd; v.eill = eill;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; inst_i = v.inst; pc_i = v.pc;
    reg1_data_i = v.r1; reg2_data_i = v.r2;
    ex_wd_i = v.exwd; ex_wreg_i = v.exwreg; ex_wdata_i = v.exwdata;
    mem_wd_i = v.mwd; mem_wreg_i = v.mwreg; mem_wdata_i = v.mwdata;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input vec_t v, input bit do_flush);
    int   cnt = 0;
    exp_t e;
    drive(v);
    flush_i = do_flush;
    #4;
    check("reg1_read", reg1_read_o, v.re1);
    check("reg2_read", reg2_read_o, v.re2);
    check("reg1_addr", reg1_addr_o, v.inst[19:15]);
    check("reg2_addr", reg2_addr_o, v.inst[24:20]);
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #5;
      cnt++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    else if (!do_flush) begin
      e.e1 = v.e1; e.e2 = v.e2; e.pc = v.pc; e.ewreg = v.ewreg; e.ewd = v.ewd; e.eill = v.eill;
      e.op = v.inst[6:0]; e.f3 = v.inst[14:12]; e.f7b5 = v.inst[30];
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush_i  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected_out", out_valid, 0);
      else begin
        got = sb.pop_front();
        check("reg1_o", reg1_o, got.e1);
        check("reg2_o", reg2_o, got.e2);
        check("wreg_o", wreg_o, got.ewreg);
        check("wd_o", wd_o, got.ewd);
        check("illegal_o", illegal_o, got.eill);
        check("aluop_o", aluop_o, got.op);
        check("alufunct3_o", alufunct3_o, got.f3);
        check("alufunct7b5_o", alufunct7b5_o, got.f7b5);
        check("pc_o", pc_o, got.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          inst          pc        r1            r2            ex wd/reg/data     mem wd/reg/data    re1 re2  e1            e2            rd  wd ill
    tbl[0]  = mk(32'hFFB00093, 32'h000, 32'hDEAD,     32'hBEEF,     0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 0, 32'h0,        32'hFFFFFFFB, 1, 1, 0);
    tbl[1]  = mk(32'h002081B3, 32'h004, 32'd7,        32'd9,        1, 5'd2, 32'h55,  1, 5'd2, 32'h66,  1, 1, 32'd7,        32'h55,       3, 1, 0);
    tbl[2]  = mk(32'h40208233, 32'h008, 32'd7,        32'd9,        0, 5'd1, 32'h11,  1, 5'd1, 32'h66,  1, 1, 32'h66,       32'd9,        4, 1, 0);
    tbl[3]  = mk(32'h00331293, 32'h00C, 32'h1234,     32'h5555,     0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 0, 32'h1234,     32'd3,        5, 1, 0);
    tbl[4]  = mk(32'h41F45393, 32'h010, 32'h80000000, 32'h0,        1, 5'd9, 32'hAB,  0, 5'd0, 32'h0,   1, 0, 32'h80000000, 32'h1F,       7, 1, 0);
    tbl[5]  = mk(32'h123452B7, 32'h014, 32'hAAAA,     32'hBBBB,     1, 5'd5, 32'hCC,  0, 5'd0, 32'h0,   0, 0, 32'h0,        32'h12345000, 5, 1, 0);
    tbl[6]  = mk(32'h00001317, 32'h100, 32'hAAAA,     32'hBBBB,     0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 0, 32'h100,      32'h1000,     6, 1, 0);
    tbl[7]  = mk(32'h000000FF, 32'h018, 32'h1,        32'h2,        0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 0, 32'h0,        32'h0,        1, 0, 1);
    tbl[8]  = mk(32'h02145393, 32'h01C, 32'h1234,     32'h0,        0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 0, 32'h0,        32'h0,        7, 0, 1);
    tbl[9]  = mk(32'h00100013, 32'h020, 32'h3,        32'h4,        0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 0, 32'h0,        32'h1,        0, 0, 0);
    tbl[10] = mk(32'hFFFFF0B7, 32'h024, 32'h3,        32'h4,        0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   0, 0, 32'h0,        32'hFFFFF000, 1, 1, 0);
    tbl[11] = mk(32'h40209233, 32'h028, 32'd7,        32'd9,        0, 5'd0, 32'h0,   0, 5'd0, 32'h0,   1, 1, 32'h0,        32'h0,        4, 0, 1);
    tbl[12] = mk(32'h000081B3, 32'h02C, 32'd5,        32'h77,       1, 5'd0, 32'h99,  1, 5'd3, 32'h88,  1, 1, 32'd5,        32'h0,        3, 1, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
    inst_i = 32'h002081B3; pc_i = 32'h40;
    reg1_data_i = '0; reg2_data_i = '0;
    ex_wd_i = 1'b0; ex_wreg_i = '0; ex_wdata_i = '0;
    mem_wd_i = 1'b0; mem_wreg_i = '0; mem_wdata_i = '0;
    repeat (2) @(posedge clk);
    #4;
    check("rst_out_valid", out_valid, 0);
    check("rst_aluop", aluop_o, 7'b0010011);
    check("rst_funct3", alufunct3_o, 0);
    check("rst_funct7b5", alufunct7b5_o, 0);
    check("rst_reg1", reg1_o, 0);
    check("rst_reg2", reg2_o, 0);
    check("rst_wreg", wreg_o, 0);
    check("rst_wd", wd_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_illegal", illegal_o, 0);
    check("rst_reg1_read", reg1_read_o, 0);
    check("rst_reg2_read", reg2_read_o, 0);
    check("rst_reg1_addr", reg1_addr_o, 0);
    check("rst_reg2_addr", reg2_addr_o, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // One-cycle latency, then out_valid clears after the transfer.
    send(tbl[0], 0);
    #4; check("latency_valid", out_valid, 1);
    @(posedge clk); #1;
    #4; check("drain_valid", out_valid, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) send(tbl[i], 0);
    repeat (2) @(posedge clk);
    #1;

    // Three-cycle stall with the next instruction waiting.
    out_ready = 1'b0;
    send(tbl[0], 0);
    drive(tbl[1]);
    for (int c = 0; c < 3; c++) begin
      #4;
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_reg2", reg2_o, 32'hFFFFFFFB);
      check("stall_wreg", wreg_o, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(tbl[1], 0);
    #4; check("stall_next_valid", out_valid, 1);
    @(posedge clk); #1;
    #4; @(posedge clk); #1;

    // Flush of a held instruction: valid drops, data stays.
    out_ready = 1'b0;
    send(tbl[2], 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    #4;
    check("flush_held_valid", out_valid, 0);
    check("flush_held_reg2", reg2_o, 32'd9);
    check("flush_held_wreg", wreg_o, 4);
    void'(sb.pop_back());
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Flush in the accept cycle blocks the load.
    send(tbl[5], 1);
    #4; check("flush_in_valid", out_valid, 0);
    @(posedge clk); #1;
    send(tbl[6], 0);
    #4; @(posedge clk); #1;

    // Asynchronous reset while stalled.
    out_ready = 1'b0;
    send(tbl[3], 0);
    #4; check("pre_rst_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_reg1", reg1_o, 0);
    check("async_rst_aluop", aluop_o, 7'b0010011);
    void'(sb.pop_back());
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(tbl[9], 0);
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised, registered successor of the combinational instruction-decode stage.
- Decodes RV32I integer ALU instructions: OP-IMM, OP (R-type), LUI and AUIPC.
- Selects operands from the register file or from forwarding paths, sign-extends immediates, and registers the result into an ID/EX output stage.
- Sits between IF/ID and EX, with a valid/ready handshake on both sides and a flush input.

Parameters:
- XLEN, 32, datapath width; immediates sign-extend to XLEN.
- REG_ADDR_W, 5, register-address width.
- FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = operands always come from the register file.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  pc_i/inst_i valid
- in_ready  out  1  stage can accept an instruction
- pc_i  in  XLEN  instruction PC
- inst_i  in  32  instruction word
- reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  REG_ADDR_W  regfile read addresses (combinational)
- reg1_data_i / reg2_data_i  in  XLEN  regfile read data (same cycle)
- ex_wd_i, ex_wreg_i, ex_wdata_i  in  1/REG_ADDR_W/XLEN  EX-stage write-back info
- mem_wd_i, mem_wreg_i, mem_wdata_i  in  1/REG_ADDR_W/XLEN  MEM-stage write-back info
- flush_i  in  1  discard the held and incoming instruction
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts the instruction
- aluop_o  out  7  opcode passed to EX
- alufunct3_o  out  3  funct3
- alufunct7b5_o  out  1  inst[30] (SUB/SRA select)
- reg1_o / reg2_o  out  XLEN  operand 1 / operand 2
- wreg_o  out  REG_ADDR_W  destination register
- wd_o  out  1  write enable
- pc_o  out  XLEN  registered PC
- illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (asynchronous, while rst=1):
  - out_valid=0, aluop_o=7'b0010011, alufunct3_o=0, alufunct7b5_o=0, reg1_o=0, reg2_o=0, wreg_o=0, wd_o=0, pc_o=0, illegal_o=0.
  - Read enables and addresses are 0.
  - Reset mid-transfer drops the instruction; nothing is replayed.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Load occurs when in_valid & in_ready.
  - Latency is exactly 1 cycle from accept to out_valid.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - A transfer out happens on out_valid & out_ready; with no new load, out_valid clears next cycle.
  - Back-to-back accept and transfer give full throughput of 1 instruction per cycle.
- Flush:
  - flush_i=1 clears out_valid next cycle and blocks any load in that cycle; flush has priority over load.
  - Data outputs keep their old values.
- Decode, per opcode:
  - OP-IMM: read rs1; op2 = sext(inst[31:20]).
    - For funct3 001/101, op2 = shamt inst[24:20] zero-extended.
    - For funct3 001/101, illegal if inst[31:25] is not 0000000, or not 0100000 (for 101 only).
  - OP: read rs1 and rs2.
    - Legal funct7 is 0000000, or 0100000 only with funct3 000/101.
  - LUI: op1 = 0, op2 = {inst[31:12], 12'b0}.
  - AUIPC: op1 = pc_i, op2 = {inst[31:12], 12'b0}.
  - Addresses: reg1_addr_o = inst[19:15], reg2_addr_o = inst[24:20].
  - wreg = inst[11:7].
  - Read enables are 0 for unused ports.
- Write enable: wd = legal & (rd != 0).
- Illegal opcode or funct encoding: illegal_o=1, wd_o=0, operands 0; the instruction still flows through with out_valid=1.
- Operand select, per read port, in priority order:
  - port not read → immediate/PC/0 as above;
  - addr == 0 → 0;
  - FWD_EN & ex_wd_i & ex_wreg_i == addr → ex_wdata_i;
  - FWD_EN & mem_wd_i & mem_wreg_i == addr → mem_wdata_i;
  - otherwise the regfile data.
- Hazards: EX wins over MEM when both match. Forwarding is sampled in the accept cycle only, not while stalled; upstream stalls until its data is valid.

Test Plan:
- Reset with out_ready=1, then accept ADDI x1,x0,-5 (0xFFB00093) → next cycle out_valid=1, reg1_o=0, reg2_o=0xFFFFFFFB, wreg_o=1, wd_o=1, alufunct3_o=0.
- ADD x3,x1,x2 with regfile x1=7, x2=9, ex_wd_i=1, ex_wreg_i=2, ex_wdata_i=0x55, mem_wreg_i=2, mem_wdata_i=0x66 → reg1_o=7, reg2_o=0x55.
- Stall: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs stable; out_ready=1 → one transfer, then the next instruction loads.
- flush_i=1 in the same cycle as accept of LUI x5,0x12345 → out_valid=0 next cycle; following AUIPC x6,1 at pc 0x100 → reg1_o=0x100, reg2_o=0x1000.
- Opcode 0x7F and SRAI with inst[31:25]=0x01 → illegal_o=1, wd_o=0, out_valid=1.
- Assert rst while out_valid=1 and out_ready=0 → out_valid=0 immediately (asynchronously); ADDI x0,x0,1 afterwards → wd_o=0.
